bcd_serial_add_ctrl: RTL and testbench
======================================

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, giving the number of BCD digits per operand (legal range 1..16).
REQ-002 SHALL have one clock and an asynchronous, active-high reset, with the following ports.
- CLK  input  1: single clock, rising edge.
- RST  input  1: asynchronous active-high reset.
REQ-003 SHALL have these remaining ports.
- IN_VALID  input  1: operands valid.
- IN_READY  output  1: controller can accept operands.
- A  input  4*NUM_DIGITS: BCD operand, digit 0 at bits [3:0].
- B  input  4*NUM_DIGITS: BCD operand.
- CI  input  1: decimal carry-in.
- OUT_VALID  output  1: result valid.
- OUT_READY  input  1: consumer accepts result.
- S  output  4*NUM_DIGITS: BCD sum.
- CO  output  1: decimal carry-out.
- BUSY  output  1: high in any state except IDLE.
- ERR  output  1: non-BCD digit flag; see Configuration.

Function
REQ-004 SHALL implement states IDLE, ADD and DONE.
REQ-005 IN_READY SHALL equal (state==IDLE); a transfer occurs on a rising edge where IN_VALID and IN_READY are both high.
REQ-006 On transfer, SHALL register A, B and CI, clear the digit index and S, and go to ADD.
REQ-007 In ADD, SHALL process one digit per cycle, LSD first, through a single shared digit adder, with carry held in a 1-bit register.
REQ-008 Per-digit rule: t = a + b + c (5-bit); if t > 9, digit = (t + 6)[3:0] and carry = 1; otherwise digit = t[3:0] and carry = 0.
REQ-009 After digit index NUM_DIGITS-1, SHALL load CO from the final carry and go to DONE; the digit index SHALL NOT wrap.
REQ-010 In DONE, OUT_VALID SHALL be 1 and S, CO and ERR SHALL be held stable until OUT_READY=1.
REQ-011 In DONE with OUT_READY=1, SHALL go to IDLE in the next cycle.
REQ-012 Latency: OUT_VALID SHALL rise exactly NUM_DIGITS+1 cycles after the accepting edge.
REQ-013 Throughput: one operation per NUM_DIGITS+2 cycles when OUT_READY is held high.
REQ-014 IN_VALID SHALL be ignored outside IDLE, and the A, B and CI inputs are don't-care after transfer.
REQ-015 S and CO SHALL be valid only while OUT_VALID=1; S SHALL retain its last value in IDLE.

Reset
REQ-016 RST SHALL asynchronously force state=IDLE, S=0, CO=0, OUT_VALID=0, BUSY=0, ERR=0 and clear the digit index and carry register.
REQ-017 Reset during ADD or DONE SHALL abort the operation with no result emitted.
REQ-018 After RST deasserts, IN_READY SHALL be 1 in the first cycle.

Configuration
REQ-019 Macro BCD_INPUT_CHECK_EN SHALL control non-BCD input checking.
REQ-020 With BCD_INPUT_CHECK_EN defined, ERR SHALL be set in DONE if any registered A or B digit > 9, and the sum SHALL still be computed per REQ-008.
REQ-021 With BCD_INPUT_CHECK_EN defined, ERR SHALL clear on the next transfer.
REQ-022 Without BCD_INPUT_CHECK_EN, ERR SHALL be tied to 0 and no check logic SHALL exist.

Structure
REQ-023 A shared package SHALL hold the state enum (IDLE/ADD/DONE), BCD_DIGIT_W=4 and BCD_MAX_DIGIT=9.
REQ-024 The per-digit adder SHALL be one combinational sub-module, bcd_digit_adder (a, b, ci -> s, co), built from the existing full-adder chain plus >9 correction.
REQ-025 The sequencing FSM, operand shift/index logic and result register SHALL reside in bcd_serial_add_ctrl.

Verification (NUM_DIGITS=4)
REQ-026 A=1234, B=5678, CI=0 -> S=6912, CO=0, with OUT_VALID 5 cycles after accept.
REQ-027 A=9999, B=0001, CI=0 -> S=0000, CO=1, with carry ripple through all four digits.
REQ-028 A=0000, B=0000, CI=1 -> S=0001, CO=0; then OUT_READY low for 3 cycles -> S and OUT_VALID stable, IN_READY=0.
REQ-029 RST asserted 2 cycles into ADD -> all outputs 0 asynchronously and IN_READY=1 after release; a subsequent 0005+0005 -> S=0010.
REQ-030 With BCD_INPUT_CHECK_EN, A=00A0, B=0000 -> ERR=1 in DONE; next legal operation -> ERR=0.
REQ-031 IN_VALID held high with OUT_READY=1 -> back-to-back ops accepted every 6 cycles and no operand is lost.

Source files
------------

// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared types and constants for the digit-serial BCD adder controller.
// Build option BCD_INPUT_CHECK_EN (see bcd_serial_add_ctrl.sv) uses is_bcd_digit().
package bcd_serial_add_ctrl_pkg;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BCD_MAX_DIGIT = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_bcd_digit(input logic [BCD_DIGIT_W-1:0] d);
    return d <= BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_digit.sv
// Combinational single-digit BCD adder: 4-bit full-adder ripple chain followed
// by the decimal correction (+6 when the binary sum exceeds 9).
module bcd_digit_adder
  import bcd_serial_add_ctrl_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] a,
  input  logic [BCD_DIGIT_W-1:0] b,
  input  logic                   ci,
  output logic [BCD_DIGIT_W-1:0] s,
  output logic                   co
);

  localparam logic [BCD_DIGIT_W:0] SUM_MAX  = (BCD_DIGIT_W+1)'(BCD_MAX_DIGIT);
  localparam logic [BCD_DIGIT_W:0] SUM_CORR = (BCD_DIGIT_W+1)'(6);

  logic [BCD_DIGIT_W:0] carry;
  logic [BCD_DIGIT_W:0] t;
  logic [BCD_DIGIT_W:0] t_fix;

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    carry = '0;
    t     = '0;
    carry[0] = ci;
    for (int i = 0; i < BCD_DIGIT_W; i++) begin
      t[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    t[BCD_DIGIT_W] = carry[BCD_DIGIT_W];
    t_fix = t + SUM_CORR;
    if (t > SUM_MAX) begin
      s  = t_fix[BCD_DIGIT_W-1:0];
      co = 1'b1;
    end else begin
      s  = t[BCD_DIGIT_W-1:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder controller: accepts two NUM_DIGITS operands, adds one
// digit per cycle LSD first. Define BCD_INPUT_CHECK_EN to flag non-BCD digits on ERR.
module bcd_serial_add_ctrl
  import bcd_serial_add_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              IN_VALID,
  output logic                              IN_READY,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] A,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] B,
  input  logic                              CI,
  output logic                              OUT_VALID,
  input  logic                              OUT_READY,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] S,
  output logic                              CO,
  output logic                              BUSY,
  output logic                              ERR
);

  localparam int W     = BCD_DIGIT_W * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                   state;
  logic [W-1:0]             a_sh;
  logic [W-1:0]             b_sh;
  logic [IDX_W-1:0]         idx;
  logic                     carry;
  logic [BCD_DIGIT_W-1:0]   dig_s;
  logic                     dig_co;
  logic [W-1:0]             s_next;

  bcd_digit_adder u_digit (
    .a  (a_sh[BCD_DIGIT_W-1:0]),
    .b  (b_sh[BCD_DIGIT_W-1:0]),
    .ci (carry),
    .s  (dig_s),
    .co (dig_co)
  );

  // Result digits enter at the top and shift down, so digit 0 lands at [3:0].
  if (NUM_DIGITS == 1) begin : g_one_digit
    assign s_next = dig_s;
  end else begin : g_multi_digit
    assign s_next = {dig_s, S[W-1:BCD_DIGIT_W]};
  end

  assign IN_READY = (state == IDLE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  // NOTE: operand/result datapath registers are reset here too, because S and
  // CO must read as zero after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      S         <= '0;
      CO        <= 1'b0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= CI;
            idx   <= '0;
            S     <= '0;
            BUSY  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          a_sh  <= a_sh >> BCD_DIGIT_W;
          b_sh  <= b_sh >> BCD_DIGIT_W;
          S     <= s_next;
          carry <= dig_co;
          if (idx == LAST_IDX) begin
            CO        <= dig_co;
            OUT_VALID <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD_INPUT_CHECK_EN
  logic err_acc;
  logic bad_digit;

  assign bad_digit = !is_bcd_digit(a_sh[BCD_DIGIT_W-1:0]) ||
                     !is_bcd_digit(b_sh[BCD_DIGIT_W-1:0]);

  // Flag accumulates per processed digit; published on entry to DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_acc <= 1'b0;
      ERR     <= 1'b0;
    end else if (IN_VALID && IN_READY) begin
      err_acc <= 1'b0;
      ERR     <= 1'b0;
    end else if (state == ADD) begin
      err_acc <= err_acc | bad_digit;
      if (idx == LAST_IDX) ERR <= err_acc | bad_digit;
    end
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (NUM_DIGITS=4): vector table,
// stall/reset/back-to-back sequences, and the ERR case when BCD_INPUT_CHECK_EN is set.
module tb_bcd_serial_add_ctrl;

  localparam int ND = 4;
  localparam int W  = 4 * ND;
  localparam int LATENCY = ND + 1;  // cycles from the accept cycle to OUT_VALID
  localparam int PERIOD  = ND + 2;

  logic         CLK = 1'b0;
  logic         RST;
  logic         IN_VALID, IN_READY, CI, OUT_VALID, OUT_READY, CO, BUSY, ERR;
  logic [W-1:0] A, B, S;

  always #5 CLK = ~CLK;

  bcd_serial_add_ctrl #(.NUM_DIGITS(ND)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .CI        (CI),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .S         (S),
    .CO        (CO),
    .BUSY      (BUSY),
    .ERR       (ERR)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the operand values.
  function automatic int bcd2int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = ND - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic exp_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int   sum;
    int   lim;
    exp_t e;
    sum = bcd2int(a) + bcd2int(b) + (ci ? 1 : 0);
    lim = 1;
    for (int i = 0; i < ND; i++) lim = lim * 10;
    e.co = (sum >= lim);
    if (e.co) sum = sum - lim;
    e.s = '0;
    for (int i = 0; i < ND; i++) begin
      e.s[4*i +: 4] = 4'(sum % 10);
      sum = sum / 10;
    end
    e.err = 1'b0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < ND; i++) v[4*i +: 4] = 4'($urandom_range(9));
    return v;
  endfunction

  // Drives one accepted transfer; leaves the bench #1 after the accepting edge.
  task automatic start_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input exp_t e, input bit push);
    int guard;
    guard = 0;
    while (!IN_READY && guard < 40) begin
      @(posedge CLK); #1;
      guard++;
    end
    check({name, "_in_ready"}, IN_READY, 1'b1);
    A = a; B = b; CI = ci; IN_VALID = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    A  = W'($urandom);
    B  = W'($urandom);
    CI = 1'($urandom);
  endtask

  // Returns the cycle in which OUT_VALID is first seen (accept cycle = 0).
  task automatic wait_out(input string name, output int lat);
    lat = 1;
    while (!OUT_VALID && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(LATENCY));
  endtask

  task automatic compare_out(input string name);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: result S=%0h with no expected entry", name, S);
    end else begin
      e = exp_q.pop_front();
      check({name, "_S"},   S,   e.s);
      check({name, "_CO"},  CO,  e.co);
      check({name, "_ERR"}, ERR, e.err);
    end
  endtask

  task automatic run_table();
    int lat;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e = '{s: tbl[i].s, co: tbl[i].co, err: 1'b0};
      start_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci, e, 1'b1);
      check($sformatf("vec%0d_busy", i), BUSY, 1'b1);
      wait_out($sformatf("vec%0d", i), lat);
      check($sformatf("vec%0d_in_ready_done", i), IN_READY, 1'b0);
      compare_out($sformatf("vec%0d", i));
      @(posedge CLK); #1;
      check($sformatf("vec%0d_out_valid_drop", i), OUT_VALID, 1'b0);
    end
  endtask

  task automatic run_stall();
    int   lat;
    exp_t e;
    e = '{s: 16'h0001, co: 1'b0, err: 1'b0};
    OUT_READY = 1'b0;
    start_op("stall", 16'h0000, 16'h0000, 1'b1, e, 1'b1);
    wait_out("stall", lat);
    // A competing request while DONE must be ignored.
    A = 16'h9999; B = 16'h9999; CI = 1'b1; IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check($sformatf("stall%0d_out_valid", i), OUT_VALID, 1'b1);
      check($sformatf("stall%0d_S", i), S, 16'h0001);
      check($sformatf("stall%0d_in_ready", i), IN_READY, 1'b0);
    end
    IN_VALID = 1'b0;
    compare_out("stall");
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    check("stall_release_out_valid", OUT_VALID, 1'b0);
    check("stall_release_busy", BUSY, 1'b0);
    check("stall_release_S_retained", S, 16'h0001);
  endtask

  task automatic run_reset_abort();
    int   lat;
    int   seen;
    exp_t e;
    e = '{s: 16'h0000, co: 1'b0, err: 1'b0};
    start_op("abort", 16'h1234, 16'h1111, 1'b0, e, 1'b0);
    @(posedge CLK); #1;
    #2 RST = 1'b1;
    #1;
    check("abort_S", S, 16'h0000);
    check("abort_CO", CO, 1'b0);
    check("abort_out_valid", OUT_VALID, 1'b0);
    check("abort_busy", BUSY, 1'b0);
    check("abort_err", ERR, 1'b0);
    #3 RST = 1'b0;
    @(posedge CLK); #1;
    check("abort_in_ready_after", IN_READY, 1'b1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (OUT_VALID) seen++;
      @(posedge CLK); #1;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    e = '{s: 16'h0010, co: 1'b0, err: 1'b0};
    start_op("post_abort", 16'h0005, 16'h0005, 1'b0, e, 1'b1);
    wait_out("post_abort", lat);
    compare_out("post_abort");
    @(posedge CLK); #1;
  endtask

  task automatic run_back_to_back();
    logic [W-1:0] va[4];
    logic [W-1:0] vb[4];
    logic         vc[4];
    int           acc_cyc[$];
    int           got;
    int           k;
    bit           accepting;
    for (int i = 0; i < 4; i++) begin
      va[i] = rand_bcd();
      vb[i] = rand_bcd();
      vc[i] = 1'($urandom_range(1));
    end
    got = 0;
    k   = 0;
    OUT_READY = 1'b1;
    A = va[0]; B = vb[0]; CI = vc[0]; IN_VALID = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 4; cyc++) begin
      accepting = IN_VALID && IN_READY;
      if (accepting) begin
        exp_q.push_back(ref_add(va[k], vb[k], vc[k]));
        acc_cyc.push_back(cyc);
        k++;
      end
      @(posedge CLK); #1;
      if (accepting) begin
        if (k < 4) begin
          A = va[k]; B = vb[k]; CI = vc[k];
        end else begin
          IN_VALID = 1'b0;
        end
      end
      if (OUT_VALID) begin
        compare_out($sformatf("b2b%0d", got));
        got++;
      end
    end
    IN_VALID = 1'b0;
    check("b2b_results", 64'(got), 64'd4);
    check("b2b_accepts", 64'(acc_cyc.size()), 64'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      check($sformatf("b2b_spacing%0d", i), 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(PERIOD));
    repeat (2) @(posedge CLK);
    #1;
  endtask

`ifdef BCD_INPUT_CHECK_EN
  task automatic run_err_check();
    int   lat;
    exp_t e;
    e = '{s: 16'h0100, co: 1'b0, err: 1'b1};
    start_op("err", 16'h00A0, 16'h0000, 1'b0, e, 1'b1);
    wait_out("err", lat);
    compare_out("err");
    @(posedge CLK); #1;
    e = '{s: 16'h0579, co: 1'b0, err: 1'b0};
    start_op("err_clear", 16'h0123, 16'h0456, 1'b0, e, 1'b1);
    check("err_clear_on_accept", ERR, 1'b0);
    wait_out("err_clear", lat);
    compare_out("err_clear");
    @(posedge CLK); #1;
  endtask
`endif

  initial begin
    tbl[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0};
    tbl[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    tbl[3] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1};
    tbl[4] = '{16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0};
    tbl[5] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1};
    tbl[6] = '{16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0};
    tbl[7] = '{16'h4321, 16'h1111, 1'b1, 16'h5433, 1'b0};

    RST = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; CI = 1'b0; OUT_READY = 1'b1;
    #1;
    check("reset_S", S, 16'h0000);
    check("reset_CO", CO, 1'b0);
    check("reset_out_valid", OUT_VALID, 1'b0);
    check("reset_busy", BUSY, 1'b0);
    check("reset_err", ERR, 1'b0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    check("reset_in_ready", IN_READY, 1'b1);

    run_table();
    run_stall();
    run_reset_abort();
    run_back_to_back();
`ifdef BCD_INPUT_CHECK_EN
    run_err_check();
`endif
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
